// File: rtl/avalon_bus_master.sv
// avalon_bus_master
//   Bridges single core load/store/fetch requests onto an Avalon-MM master
//   port. It produces one response per accepted request.
//
//   Ports:
//     clk, reset       clock; asynchronous active-low reset
//     req_*            core request: valid/ready, write, addr, size, signed, wdata
//     rsp_*            one-cycle response: valid, rdata (extended), err
//     address, read, write, waitrequest, writedata, byteenable, readdata
//                      Avalon-MM master bus
//     dbg_state        current FSM state (IDLE=0, BUS=1, RESP=2)
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1. req_ready is 1 only in IDLE. The req_* fields are
//   sampled only on that edge. rsp_valid is a one-cycle pulse that is not
//   back-pressured. rsp_err qualifies it. A bus transfer completes on an edge
//   where read or write is 1 and waitrequest is 0. All bus outputs stay
//   constant until that edge.
module avalon_bus_master #(
  parameter int STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [1:0]  dbg_state
);

  localparam int CW = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;
  logic          lat_write;
  logic [1:0]    lat_size;
  logic [1:0]    lat_lo;
  logic          lat_signed;

  // Decode the incoming request: legality, lane enables and lane-shifted data.
  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wlane;

  always_comb begin
    req_bad   = 1'b0;
    req_be    = 4'b0000;
    req_wlane = 32'h0;
    case (req_size)
      2'd0: begin
        req_be    = 4'b0001 << req_addr[1:0];
        req_wlane = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
      end
      2'd1: begin
        req_bad   = req_addr[0];
        req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wlane = {16'h0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
      end
      2'd2: begin
        req_bad   = |req_addr[1:0];
        req_be    = 4'b1111;
        req_wlane = req_wdata;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0 and extend it to 32 bits.
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  always_comb begin
    rd_shift = readdata >> {lat_lo, 3'b000};
    case (lat_size)
      2'd0:    rd_ext = lat_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                   : {24'h0, rd_shift[7:0]};
      2'd1:    rd_ext = lat_signed ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                   : {16'h0, rd_shift[15:0]};
      default: rd_ext = readdata;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      stall_cnt  <= '0;
      lat_write  <= 1'b0;
      lat_size   <= 2'd0;
      lat_lo     <= 2'd0;
      lat_signed <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      address    <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'h0;
      byteenable <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_size   <= req_size;
            lat_lo     <= req_addr[1:0];
            lat_signed <= req_signed;
            if (req_bad) begin
              // Illegal or misaligned request: answer at once and skip the bus.
              state     <= S_RESP;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state      <= S_BUS;
              address    <= {req_addr[31:2], 2'b00};
              read       <= ~req_write;
              write      <= req_write;
              byteenable <= req_be;
              writedata  <= req_write ? req_wlane : 32'h0;
              stall_cnt  <= '0;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= lat_write ? 32'h0 : rd_ext;
            state     <= S_RESP;
          end else if (stall_cnt == LIMIT) begin
            // The strobe has been high for STALL_LIMIT+1 cycles, so give up.
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            state     <= S_RESP;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        S_RESP: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bus_master.sv
module tb_avalon_bus_master;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected responses, {err, rdata}, in acceptance order.
  logic [32:0] exp_q[$];

  avalon_bus_master #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- slave RAM model ----------------
  logic [31:0] ram     [64] = '{4: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] ref_mem [64] = '{4: 32'hDEADBEEF, default: 32'h0};
  int stall_cfg  = 0;
  int stall_seen = 0;

  assign waitrequest = (read || write) && (stall_seen < stall_cfg);
  assign readdata    = ram[address[7:2]];

  always @(posedge clk) begin
    if (read || write) stall_seen <= stall_seen + 1;
    else               stall_seen <= 0;
    if (write && !waitrequest) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) ram[address[7:2]][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- response scoreboard and bus invariants ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk("rd_wr_exclusive", 64'(read && write), 64'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("rsp_err",   64'(rsp_err),   64'(e[32]));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request, then watches until the response pulse. Reports the
  // response cycle relative to the acceptance edge T, the strobe cycle count
  // and the bus values seen on the first strobe cycle.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wd, input int stalls,
                        output int lat, output int strobes, output logic [31:0] b_addr,
                        output logic [3:0] b_be, output logic [31:0] b_wd,
                        output logic b_rd, output logic b_wr, output logic stable);
    int guard;
    stall_cfg = stalls;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("req_ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size = size; req_signed = sgn; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble the request fields; they must be ignored from here on.
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = $urandom;
    lat = 0; strobes = 0; stable = 1'b1;
    b_addr = '0; b_be = '0; b_wd = '0; b_rd = 1'b0; b_wr = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (read || write) begin
        if (strobes == 0) begin
          b_addr = address; b_be = byteenable; b_wd = writedata; b_rd = read; b_wr = write;
        end else if (address !== b_addr || byteenable !== b_be || writedata !== b_wd ||
                     read !== b_rd || write !== b_wr) begin
          stable = 1'b0;
        end
        strobes++;
      end
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_checked(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                             input int stalls, input logic e_err, input logic [31:0] e_addr,
                             input logic [3:0] e_be, input logic [31:0] e_wd,
                             input logic [31:0] e_rdata, input int e_lat, input int e_strobes);
    int lat, strobes;
    logic [31:0] b_addr, b_wd;
    logic [3:0]  b_be;
    logic b_rd, b_wr, stable;
    exp_q.push_back({e_err, e_rdata});
    do_txn(wr, addr, size, sgn, wd, stalls, lat, strobes, b_addr, b_be, b_wd, b_rd, b_wr, stable);
    chk({tag, "_lat"},     64'(lat),     64'(e_lat));
    chk({tag, "_strobes"}, 64'(strobes), 64'(e_strobes));
    if (e_strobes > 0) begin
      chk({tag, "_stable"}, 64'(stable), 64'd1);
      chk({tag, "_addr"},   64'(b_addr), 64'(e_addr));
      chk({tag, "_be"},     64'(b_be),   64'(e_be));
      chk({tag, "_kind"},   64'({b_rd, b_wr}), 64'({~wr, wr}));
      if (wr) chk({tag, "_wdata"}, 64'(b_wd), 64'(e_wd));
    end
    if (wr && !e_err) begin
      for (int i = 0; i < 4; i++)
        if (e_be[i]) ref_mem[addr[7:2]][8*i +: 8] = e_wd[8*i +: 8];
    end
  endtask

  // ---------------- reference model ----------------
  // Works from access width in bytes and plain masks/shifts.
  task automatic model(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wd, input int stalls,
                       output logic err, output logic [3:0] be, output logic [31:0] bwd,
                       output logic [31:0] rdata, output int lat, output int strobes);
    int nbytes, lo;
    logic [31:0] mask, v;
    nbytes = 1 << size;
    lo = int'(addr[1:0]);
    err = (size == 2'd3) || ((lo % nbytes) != 0);
    mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    be = 4'(((1 << nbytes) - 1) << lo);
    bwd = (wd & mask) << (8 * lo);
    v = (ref_mem[addr[7:2]] >> (8 * lo)) & mask;
    if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
    if (err) begin
      be = '0; bwd = '0; rdata = '0; lat = 1; strobes = 0;
    end else if (stalls > LIMIT) begin
      err = 1'b1; rdata = '0; lat = LIMIT + 2; strobes = LIMIT + 1;
    end else begin
      rdata = wr ? 32'h0 : v; lat = 2 + stalls; strobes = stalls + 1;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    int          stalls;
    logic        e_err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_strobes;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        0,  1'b0, 32'h10, 4'b1111, 32'h0,        32'hDEADBEEF, 2, 1};
    vecs[1]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'h80FF7F01, 0,  1'b0, 32'h10, 4'b1111, 32'h80FF7F01, 32'h0,        2, 1};
    vecs[2]  = '{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        0,  1'b0, 32'h10, 4'b1000, 32'h0,        32'hFFFFFF80, 2, 1};
    vecs[3]  = '{1'b0, 32'h12, 2'd1, 1'b0, 32'h0,        0,  1'b0, 32'h10, 4'b1100, 32'h0,        32'h000080FF, 2, 1};
    vecs[4]  = '{1'b1, 32'h21, 2'd0, 1'b0, 32'h000000AB, 0,  1'b0, 32'h20, 4'b0010, 32'h0000AB00, 32'h0,        2, 1};
    vecs[5]  = '{1'b0, 32'h03, 2'd1, 1'b0, 32'h0,        0,  1'b1, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[6]  = '{1'b0, 32'h10, 2'd3, 1'b0, 32'h0,        0,  1'b1, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[7]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        3,  1'b0, 32'h10, 4'b1111, 32'h0,        32'h80FF7F01, 5, 4};
    vecs[8]  = '{1'b0, 32'h10, 2'd1, 1'b1, 32'h0,        0,  1'b0, 32'h10, 4'b0011, 32'h0,        32'h00007F01, 2, 1};
    vecs[9]  = '{1'b0, 32'h11, 2'd0, 1'b1, 32'h0,        0,  1'b0, 32'h10, 4'b0010, 32'h0,        32'h0000007F, 2, 1};
    vecs[10] = '{1'b0, 32'h20, 2'd2, 1'b0, 32'h0,        0,  1'b0, 32'h20, 4'b1111, 32'h0,        32'h0000AB00, 2, 1};
    vecs[11] = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        10, 1'b1, 32'h10, 4'b1111, 32'h0,        32'h0,        6, 5};
    vecs[12] = '{1'b1, 32'h16, 2'd1, 1'b0, 32'h1234ABCD, 1,  1'b0, 32'h14, 4'b1100, 32'hABCD0000, 32'h0,        3, 2};

    // ---------------- reset ----------------
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("rst_rsp_err",    64'(rsp_err),    64'd0);
    chk("rst_rsp_rdata",  64'(rsp_rdata),  64'd0);
    chk("rst_strobes",    64'({read, write}), 64'd0);
    chk("rst_address",    64'(address),    64'd0);
    chk("rst_writedata",  64'(writedata),  64'd0);
    chk("rst_byteenable", 64'(byteenable), 64'd0);
    @(posedge clk); #1;

    // ---------------- directed table ----------------
    for (int i = 0; i < 13; i++) begin
      run_checked($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size,
                  vecs[i].sgn, vecs[i].wdata, vecs[i].stalls, vecs[i].e_err,
                  vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wd, vecs[i].e_rdata,
                  vecs[i].e_lat, vecs[i].e_strobes);
    end

    // ---------------- reset during a stalled write ----------------
    stall_cfg = 100;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_size = 2'd2;
    req_signed = 1'b0; req_wdata = 32'h5555AAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_write_before", 64'(write), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_write_dropped", 64'(write), 64'd0);
    chk("abort_read_low",      64'(read),  64'd0);
    chk("abort_no_rsp",        64'(rsp_valid), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    run_checked("after_abort", 1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 0,
                1'b0, 32'h30, 4'b1111, 32'h0, 32'h0, 2, 1);

    // ---------------- randomized against the model ----------------
    for (int n = 0; n < 200; n++) begin
      logic        wr, sgn, e_err;
      logic [31:0] addr, wd, e_wd, e_rd;
      logic [1:0]  size;
      logic [3:0]  e_be;
      int          stalls, e_lat, e_str;
      wr     = 1'($urandom);
      addr   = $urandom;
      size   = 2'($urandom_range(0, 3));
      sgn    = 1'($urandom);
      wd     = $urandom;
      stalls = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 3);
      model(wr, addr, size, sgn, wd, stalls, e_err, e_be, e_wd, e_rd, e_lat, e_str);
      run_checked($sformatf("rnd%0d", n), wr, addr, size, sgn, wd, stalls, e_err,
                  {addr[31:2], 2'b00}, e_be, e_wd, e_rd, e_lat, e_str);
    end

    // ---------------- final memory and queue check ----------------
    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++)
      chk($sformatf("ram%0d", i), 64'(ram[i]), 64'(ref_mem[i]));
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
